// File: rtl/pitch_pkg.sv
// pitch_pkg: shared widths, default thresholds and FSM state type for the
// pitch detector.
//   SAMPLE_W / PERIOD_W : sample and period widths
//   ACC_W               : width of the period accumulator
//   *_DEFAULT           : default hysteresis / period limits
//   DC_W / DC_FRAC      : DC estimate format (12.6 fixed point)
//   pitch_state_e       : zero-crossing tracker states
//   sat_sample()        : clamps a one-bit-wider signed value to SAMPLE_W
package pitch_pkg;

    localparam int SAMPLE_W = 12;
    localparam int PERIOD_W = 10;
    localparam int ACC_W    = 12;

    localparam int HYST_DEFAULT       = 64;
    localparam int MIN_PERIOD_DEFAULT = 16;
    localparam int MAX_PERIOD_DEFAULT = 1023;

    localparam int DC_W    = 18;
    localparam int DC_FRAC = 6;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } pitch_state_e;

    // Clamp a (SAMPLE_W+1)-bit signed difference into the SAMPLE_W range.
    function automatic logic [SAMPLE_W-1:0] sat_sample(input logic [SAMPLE_W:0] v);
        logic [SAMPLE_W-1:0] r;
        if (v[SAMPLE_W] != v[SAMPLE_W-1]) begin
            r = v[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else begin
            r = v[SAMPLE_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/pitch_dc_block.sv
// pitch_dc_block: running DC estimate removed from the incoming samples.
//   clk          : clock
//   reset        : synchronous active-high reset (estimate cleared to 0)
//   sample_valid : qualifies sample
//   sample       : signed input sample
//   sample_out   : sample minus the current DC estimate, saturated
// The output uses the estimate held before this sample's update, so the
// path is purely combinational and adds no latency.
module pitch_dc_block
    import pitch_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    output logic [SAMPLE_W-1:0] sample_out
);

    logic signed [DC_W-1:0]     dc_q;
    logic signed [DC_W-1:0]     dc_d;
    logic signed [DC_W-1:0]     samp_fx;
    logic signed [DC_W:0]       diff;
    logic signed [DC_W:0]       step;
    logic signed [DC_W:0]       dc_sum;
    logic [SAMPLE_W-1:0]        dc_int;
    logic [SAMPLE_W:0]          s_wide;

    always_comb begin
        samp_fx = {sample, {DC_FRAC{1'b0}}};
        diff    = {samp_fx[DC_W-1], samp_fx} - {dc_q[DC_W-1], dc_q};
        // Arithmetic shift: the estimate moves 1/64 of the error per sample.
        step    = diff >>> DC_FRAC;
        dc_sum  = {dc_q[DC_W-1], dc_q} + step;
        dc_d    = sample_valid ? dc_sum[DC_W-1:0] : dc_q;
        // Integer part of the estimate (floor of the 12.6 value).
        dc_int  = dc_q[DC_W-1:DC_FRAC];
        s_wide  = {sample[SAMPLE_W-1], sample} - {dc_int[SAMPLE_W-1], dc_int};
        sample_out = sat_sample(s_wide);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dc_q <= '0;
        end else begin
            dc_q <= dc_d;
        end
    end

endmodule

// File: rtl/pitch_detect.sv
// pitch_detect: hysteresis zero-crossing pitch tracker.
//   clk          : clock
//   reset        : synchronous active-high reset
//   sample_valid : one-cycle strobe qualifying sample
//   sample       : signed PCM sample
//   period_out   : average of 2^AVG_LOG2 accepted periods, in samples
//   period_valid : one-cycle pulse when period_out updates
//   voiced       : high while a periodic input is being tracked
// Build option: define PITCH_DC_BLOCK_EN to subtract a running DC estimate
// (pitch_dc_block) from the samples before crossing detection.
module pitch_detect
    import pitch_pkg::*;
#(
    parameter int HYST       = HYST_DEFAULT,
    parameter int MIN_PERIOD = MIN_PERIOD_DEFAULT,
    parameter int MAX_PERIOD = MAX_PERIOD_DEFAULT,
    parameter int AVG_LOG2   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    output logic [PERIOD_W-1:0] period_out,
    output logic                period_valid,
    output logic                voiced
);

    localparam int NW = AVG_LOG2 + 1;
    localparam logic signed [SAMPLE_W-1:0] HYST_P    = SAMPLE_W'(HYST);
    localparam logic signed [SAMPLE_W-1:0] HYST_N    = SAMPLE_W'(-HYST);
    localparam logic [PERIOD_W-1:0]        MIN_P     = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0]        MAX_P     = PERIOD_W'(MAX_PERIOD);
    localparam logic [NW-1:0]              NACC_FULL = NW'(1 << AVG_LOG2);

    logic [SAMPLE_W-1:0]        s_cond;
    logic signed [SAMPLE_W-1:0] s_signed;
    logic                       above;
    logic                       below;

`ifdef PITCH_DC_BLOCK_EN
    pitch_dc_block u_dc_block (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample       (sample),
        .sample_out   (s_cond)
    );
`else
    assign s_cond = sample;
`endif

    assign s_signed = s_cond;
    assign above    = (s_signed > HYST_P);
    assign below    = (s_signed < HYST_N);

    pitch_state_e        state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [NW-1:0]       nacc_q, nacc_d;
    logic                ref_q, ref_d;      // a reference crossing has been seen
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                pv_q, pv_d;
    logic                voiced_q, voiced_d;

    logic [PERIOD_W-1:0] cnt_inc;
    logic [ACC_W-1:0]    acc_sum;
    logic [NW-1:0]       nacc_inc;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        nacc_d   = nacc_q;
        ref_d    = ref_q;
        period_d = period_q;
        pv_d     = 1'b0;
        voiced_d = voiced_q;
        cnt_inc  = cnt_q + PERIOD_W'(1);
        acc_sum  = acc_q + ACC_W'(cnt_q);
        nacc_inc = nacc_q + NW'(1);

        if (sample_valid) begin
            unique case (state_q)
                ST_SYNC: begin
                    // Arm on the first clearly negative sample; count from 0.
                    if (below) begin
                        state_d = ST_LOW;
                        cnt_d   = '0;
                    end
                end
                ST_LOW, ST_HIGH: begin
                    if (state_q == ST_LOW && above) begin
                        // Rising crossing: cnt_q is the number of samples
                        // since the previous crossing sample.
                        state_d = ST_HIGH;
                        cnt_d   = PERIOD_W'(1);
                        ref_d   = 1'b1;
                        if (ref_q) begin
                            if (cnt_q >= MIN_P) begin
                                if (nacc_inc == NACC_FULL) begin
                                    period_d = PERIOD_W'(acc_sum >> AVG_LOG2);
                                    pv_d     = 1'b1;
                                    voiced_d = 1'b1;
                                    acc_d    = '0;
                                    nacc_d   = '0;
                                end else begin
                                    acc_d  = acc_sum;
                                    nacc_d = nacc_inc;
                                end
                            end else begin
                                // Too short to be a pitch period: restart average.
                                acc_d  = '0;
                                nacc_d = '0;
                            end
                        end
                    end else begin
                        if (state_q == ST_HIGH && below) begin
                            state_d = ST_LOW;
                        end
                        cnt_d = cnt_inc;
                        if (cnt_inc == MAX_P) begin
                            // Silence timeout: drop tracking, keep last period.
                            state_d  = ST_SYNC;
                            cnt_d    = '0;
                            acc_d    = '0;
                            nacc_d   = '0;
                            ref_d    = 1'b0;
                            voiced_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = ST_SYNC;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_SYNC;
            cnt_q    <= '0;
            acc_q    <= '0;
            nacc_q   <= '0;
            ref_q    <= 1'b0;
            period_q <= '0;
            pv_q     <= 1'b0;
            voiced_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            nacc_q   <= nacc_d;
            ref_q    <= ref_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            voiced_q <= voiced_d;
        end
    end

    assign period_out   = period_q;
    assign period_valid = pv_q;
    assign voiced       = voiced_q;

endmodule

// File: tb/tb_pitch_detect.sv
// tb_pitch_detect: self-checking bench for pitch_detect. A sample-level
// reference model (queue of accepted periods, plain integer arithmetic)
// predicts period_valid / period_out / voiced after every sample.
// Honours PITCH_DC_BLOCK_EN the same way the design does.
module tb_pitch_detect;

    localparam int HYST  = 64;
    localparam int MIN_P = 16;
    localparam int MAX_P = 1023;
    localparam int AVG_N = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_valid;
    logic [11:0] sample;
    logic [9:0]  period_out;
    logic        period_valid;
    logic        voiced;

    always #5 clk = ~clk;

    pitch_detect dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample       (sample),
        .period_out   (period_out),
        .period_valid (period_valid),
        .voiced       (voiced)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_mode;        // 0 = waiting for arm, 1 = below, 2 = above
    int m_cnt;         // samples counted since the last anchor
    bit m_ref;
    int m_q[$];        // accepted periods waiting to be averaged
    int m_period;
    bit m_voiced;
    bit m_pv;
    int m_dc;

    int sidx;          // sample index within the current test
    int pv_seen;
    int pv_at;
    int voiced_fall;

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_ref = 0; m_q.delete();
        m_period = 0; m_voiced = 0; m_pv = 0; m_dc = 0;
    endtask

    task automatic model_step(input int x);
        int s;
        int sum;
        s = x;
`ifdef PITCH_DC_BLOCK_EN
        s = x - (m_dc >>> 6);
        if (s > 2047) s = 2047;
        if (s < -2048) s = -2048;
        m_dc = m_dc + ((x * 64 - m_dc) >>> 6);
`endif
        m_pv = 0;
        if (m_mode == 0) begin
            if (s < -HYST) begin
                m_mode = 1;
                m_cnt  = 0;
            end
        end else if (m_mode == 1 && s > HYST) begin
            m_mode = 2;
            if (m_ref) begin
                if (m_cnt >= MIN_P) begin
                    m_q.push_back(m_cnt);
                    if (m_q.size() == AVG_N) begin
                        sum = 0;
                        foreach (m_q[i]) sum += m_q[i];
                        m_period = sum / AVG_N;
                        m_pv = 1;
                        m_voiced = 1;
                        m_q.delete();
                    end
                end else begin
                    m_q.delete();
                end
            end
            m_ref = 1;
            m_cnt = 1;
        end else begin
            if (m_mode == 2 && s < -HYST) m_mode = 1;
            m_cnt++;
            if (m_cnt == MAX_P) begin
                m_mode = 0; m_cnt = 0; m_ref = 0; m_voiced = 0; m_q.delete();
            end
        end
    endtask

    // Present one sample, then gap-1 idle cycles. Called at posedge+1.
    task automatic send(input int x, input int gap);
        bit v_before;
        v_before     = voiced;
        sample_valid = 1'b1;
        sample       = 12'(x);
        @(posedge clk); #1;
        sample_valid = 1'b0;
        model_step(x);
        check("period_valid", period_valid, m_pv);
        check("period_out", period_out, m_period);
        check("voiced", voiced, m_voiced);
        if (period_valid === 1'b1) begin
            pv_seen++;
            pv_at = sidx;
        end
        if (v_before === 1'b1 && voiced === 1'b0) voiced_fall = sidx;
        sidx++;
        for (int i = 1; i < gap; i++) begin
            @(posedge clk); #1;
            check("pv_idle", period_valid, 0);
        end
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            sample_valid = (i % 2 == 0);
            sample       = 12'(-500);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        sample_valid = 1'b0;
        model_reset();
        sidx = 0; pv_seen = 0; pv_at = -1; voiced_fall = -1;
    endtask

    // Low half first, so the first rising crossing lands at sample period/2.
    task automatic square(input int lo, input int hi, input int period, input int cycles, input int gap);
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < period / 2; i++) send(lo, gap);
            for (int i = period / 2; i < period; i++) send(hi, gap);
        end
    endtask

    int glitch_list[7] = '{40, 40, 8, 40, 40, 40, 40};

    initial begin
        reset = 1'b1;
        sample_valid = 1'b0;
        sample = '0;
        model_reset();
        @(posedge clk); #1;

        // Reset held 3 cycles with sample_valid toggling.
        do_reset(3);
        check("rst_period_out", period_out, 0);
        check("rst_period_valid", period_valid, 0);
        check("rst_voiced", voiced, 0);
        $display("txn reset: period_out=%0d voiced=%0d", period_out, voiced);

        // +-500 square, period 40, one sample every 4th clock.
        square(-500, 500, 40, 5, 4);
        check("sq40_pv_count", pv_seen, 1);
        check("sq40_pv_at_5th_crossing", pv_at, 180);
        check("sq40_period", period_out, 40);
        check("sq40_voiced", voiced, 1);
        $display("txn square40: pulses=%0d period_out=%0d voiced=%0d", pv_seen, period_out, voiced);

        // Silence after tracking: count was 20 after the last crossing,
        // so it reaches 1023 on zero-sample index 1002.
        sidx = 0; voiced_fall = -1;
        for (int i = 0; i < 1100; i++) send(0, 1);
        check("silence_fall_idx", voiced_fall, 1002);
        check("silence_voiced", voiced, 0);
        check("silence_period_hold", period_out, 40);
        $display("txn silence: voiced fell at %0d, period_out=%0d", voiced_fall, period_out);

        // Bounded noise never passes the hysteresis band.
        pv_seen = 0;
        for (int i = 0; i < 2000; i++) send(int'($urandom_range(0, 100)) - 50, 1);
        check("noise_pv_count", pv_seen, 0);
        check("noise_voiced", voiced, 0);
        $display("txn noise: pulses=%0d voiced=%0d", pv_seen, voiced);

        // Glitch: 40,40,8,40,40,40,40 -> one pulse on the last crossing.
        do_reset(1);
        for (int i = 0; i < 20; i++) send(-500, 1);
        foreach (glitch_list[k]) begin
            for (int i = 0; i < glitch_list[k] / 2; i++) send(500, 1);
            for (int i = glitch_list[k] / 2; i < glitch_list[k]; i++) send(-500, 1);
        end
        send(500, 1);
        check("glitch_pv_count", pv_seen, 1);
        check("glitch_pv_at", pv_at, 268);
        check("glitch_period", period_out, 40);
        $display("txn glitch: pulses=%0d at %0d period_out=%0d", pv_seen, pv_at, period_out);

        // Reset mid-measurement discards the partial average.
        do_reset(1);
        square(-400, 400, 30, 3, 1);
        do_reset(1);
        square(-400, 400, 60, 5, 1);
        check("midreset_pv_count", pv_seen, 1);
        check("midreset_period", period_out, 60);
        $display("txn midreset: pulses=%0d period_out=%0d", pv_seen, period_out);

        // Randomized periodic input with noise, short glitches and gaps.
        for (int run = 0; run < 6; run++) begin
            int amp;
            int p;
            do_reset(1);
            amp = int'($urandom_range(150, 1500));
            for (int i = 0; i < 10; i++)
                send(-amp + int'($urandom_range(0, 60)) - 30, int'($urandom_range(1, 4)));
            for (int k = 0; k < 12; k++) begin
                p = ($urandom_range(0, 5) == 0) ? int'($urandom_range(2, 15))
                                                : int'($urandom_range(MIN_P, 120));
                for (int i = 0; i < p / 2; i++)
                    send(amp + int'($urandom_range(0, 60)) - 30, int'($urandom_range(1, 4)));
                for (int i = p / 2; i < p; i++)
                    send(-amp + int'($urandom_range(0, 60)) - 30, int'($urandom_range(1, 4)));
            end
            send(amp, 1);
            $display("txn random run %0d: amp=%0d pulses=%0d period_out=%0d voiced=%0d",
                     run, amp, pv_seen, period_out, voiced);
        end

        // Offset square 300 +- 200, period 50.
        do_reset(1);
        square(100, 500, 50, 30, 1);
`ifdef PITCH_DC_BLOCK_EN
        check("dc_pulsed", (pv_seen > 0) ? 1 : 0, 1);
        check("dc_period", period_out, 50);
`else
        check("nodc_pv_count", pv_seen, 0);
        check("nodc_voiced", voiced, 0);
`endif
        $display("txn offset square: pulses=%0d period_out=%0d", pv_seen, period_out);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
